// File: rtl/ca_ram_reader_if.sv
// CA_RAM read port plus the valid/ready output stream of the readback engine.
interface ca_ram_reader_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output rd_en, rd_addr, out_data, out_valid, out_last,
      input  rd_data, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_data, out_valid, out_last,
      output rd_data, out_ready
   );
endinterface

// File: rtl/ca_ram_reader.sv
// CA_RAM readback engine: streams rows 0..line_count-1 through a 2-entry output buffer.
// Define CA_READER_REVERSE_EN to read rows in descending order (line_count-1 down to 0).
module ca_ram_reader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W:0]     line_count,
   ca_ram_reader_if.master     bus,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t            state;
   logic [ADDR_W:0]   lc;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_inc;
   logic [ADDR_W-1:0] addr;
   logic              inflight;
   logic              inflight_last;
   logic [DATA_W-1:0] buf_data [2];
   logic [1:0]        buf_last;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        occ;
   logic [1:0]        occ_nxt;
   logic              pop;
   logic              issue;
   logic              last_issue;

   // Issue is decided combinationally so a pop frees a slot in the same cycle.
   always_comb begin
      pop        = (occ != 2'd0) && bus.out_ready;
      issue      = (state == ISSUE) &&
                   (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
      cnt_inc    = cnt + {{ADDR_W{1'b0}}, 1'b1};
      last_issue = issue && (cnt_inc == lc);
      occ_nxt    = occ + {1'b0, inflight} - {1'b0, pop};
   end

   assign bus.rd_en     = issue;
   assign bus.rd_addr   = addr;
   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_data  = buf_data[rd_ptr];
   assign bus.out_last  = buf_last[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         lc            <= '0;
         cnt           <= '0;
         addr          <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         buf_data[0]   <= '0;
         buf_data[1]   <= '0;
         buf_last      <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         occ           <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= last_issue;
         occ           <= occ_nxt;
         done          <= 1'b0;

         if (issue) begin
            cnt <= cnt_inc;
`ifdef CA_READER_REVERSE_EN
            addr <= addr - {{(ADDR_W-1){1'b0}}, 1'b1};
`else
            addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
         end

         if (inflight) begin
            buf_data[wr_ptr] <= bus.rd_data;
            buf_last[wr_ptr] <= inflight_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;

         case (state)
            IDLE: begin
               if (start) begin
                  lc   <= line_count;
                  cnt  <= '0;
`ifdef CA_READER_REVERSE_EN
                  addr <= line_count[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
`else
                  addr <= '0;
`endif
                  busy <= 1'b1;
                  if (line_count == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (last_issue) state <= DRAIN;
            end
            DRAIN: begin
               // Popping the entry tagged last means buffer and read pipe are both empty.
               if (pop && buf_last[rd_ptr]) begin
                  state <= FIN;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ca_ram_reader.sv
// Self-checking bench for ca_ram_reader: vector table, randomized runs and reset/back-pressure corners.
module tb_ca_ram_reader;
   localparam int AW = 7;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   line_count;
   logic          busy;
   logic          done;

   ca_ram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ca_ram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .line_count (line_count),
      .bus        (bus),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [2**AW];
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void check(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // ready pattern: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random, 3 = always low
   int mode = 0;
   int pat_idx = 0;
   always @(posedge clk) begin
      #1;
      case (mode)
         0: bus.out_ready = 1'b1;
         1: begin
            bus.out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            pat_idx++;
         end
         2: bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b0;
      endcase
   end

   // reference model: the word sequence a run must produce
   logic [DW-1:0] exp_data [$];
   bit            exp_last [$];
   int            exp_addr [$];

   bit            mon_en = 1'b0;
   int            issued, xfers, rd_cnt, valid_cnt, done_cnt;
   int            first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
   bit            prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   task automatic clear_stats();
      issued = 0; xfers = 0; rd_cnt = 0; valid_cnt = 0; done_cnt = 0;
      first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
      prev_stall = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         automatic bit pop = bus.out_valid && bus.out_ready;
         if (bus.rd_en) begin
            rd_cnt++;
            check((issued - xfers - int'(pop)) < 2, "no_overflow", issued - xfers, int'(pop));
            if (exp_addr.size() == 0) check(1'b0, "extra_rd", bus.rd_addr, 0);
            else begin
               check(int'(bus.rd_addr) == exp_addr[0], "rd_addr", bus.rd_addr, exp_addr[0]);
               void'(exp_addr.pop_front());
            end
            issued++;
         end
         if (prev_stall)
            check(bus.out_valid && bus.out_data == prev_data && bus.out_last == prev_last,
                  "stall_stable", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, prev_last, prev_data});
         if (bus.out_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (pop) begin
            if (exp_data.size() == 0) check(1'b0, "extra_word", bus.out_data, 0);
            else begin
               check(bus.out_data == exp_data[0] && bus.out_last == exp_last[0], "word",
                     {bus.out_last, bus.out_data}, {exp_last[0], exp_data[0]});
               void'(exp_data.pop_front());
               void'(exp_last.pop_front());
            end
            xfers++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
      end
   end

   task automatic build_expect(input int lc);
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      for (int i = 0; i < lc; i++) begin
`ifdef CA_READER_REVERSE_EN
         automatic int a = lc - 1 - i;
`else
         automatic int a = i;
`endif
         exp_addr.push_back(a);
         exp_data.push_back(mem[a]);
         exp_last.push_back(i == lc - 1);
      end
   endtask

   // one complete run; extra > 0 pulses a second start that many cycles in
   task automatic run_one(input int lc, input int md, input int extra, input int first_lat, input int span);
      int t_start;
      int n;
      build_expect(lc);
      clear_stats();
      @(posedge clk); #2;
      mode = md; pat_idx = 0;
      line_count = (AW+1)'(lc);
      start = 1'b1;
      t_start = cyc;
      @(posedge clk); #2;
      start = 1'b0;
      line_count = (AW+1)'($urandom);
      check(busy == 1'b1, "busy_after_start", busy, 1);
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         @(posedge clk); #2;
         start = (extra > 0 && n == extra);
         if (start) line_count = (AW+1)'(5);
         n++;
      end
      start = 1'b0;
      check(done_cnt == 1, "done_seen", done_cnt, 1);
      repeat (3) @(posedge clk);
      #2;
      check(done_cnt == 1 && busy == 1'b0, "single_done_idle", {done_cnt, busy}, {1, 1'b0});
      check(exp_data.size() == 0, "all_words", exp_data.size(), 0);
      check(rd_cnt == lc, "read_count", rd_cnt, lc);
      if (lc == 0) begin
         check(valid_cnt == 0, "zero_no_valid", valid_cnt, 0);
         check(done_cyc == t_start + 1, "zero_done_time", done_cyc - t_start, 1);
      end else begin
         check(done_cyc == last_xfer_cyc + 1, "done_after_last", done_cyc - last_xfer_cyc, 1);
         if (first_lat > 0)
            check(first_valid_cyc - t_start == first_lat, "first_latency", first_valid_cyc - t_start, first_lat);
         if (span >= 0)
            check(last_xfer_cyc - first_xfer_cyc == span, "gapless", last_xfer_cyc - first_xfer_cyc, span);
      end
      mode = 0;
   endtask

   typedef struct {
      int lc;
      int md;
      int extra;
      int first_lat;
      int span;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{lc: 5,   md: 0, extra: 0,  first_lat: 3, span: 4};
      vecs[1] = '{lc: 0,   md: 0, extra: 0,  first_lat: 0, span: -1};
      vecs[2] = '{lc: 8,   md: 1, extra: 0,  first_lat: 3, span: -1};
      vecs[3] = '{lc: 1,   md: 0, extra: 0,  first_lat: 3, span: 0};
      vecs[4] = '{lc: 2,   md: 1, extra: 0,  first_lat: 3, span: -1};
      vecs[5] = '{lc: 128, md: 0, extra: 40, first_lat: 3, span: 127};
      vecs[6] = '{lc: 16,  md: 2, extra: 0,  first_lat: 3, span: -1};

      for (int a = 0; a < 2**AW; a++) mem[a] = DW'(a + 16'h100);

      rst = 1'b1; start = 1'b0; line_count = '0; bus.out_ready = 1'b1;
      #12;
      check(bus.rd_en == 1'b0,     "rst_rd_en",     bus.rd_en, 0);
      check(bus.rd_addr == '0,     "rst_rd_addr",   bus.rd_addr, 0);
      check(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
      check(bus.out_data == '0,    "rst_out_data",  bus.out_data, 0);
      check(bus.out_last == 1'b0,  "rst_out_last",  bus.out_last, 0);
      check(busy == 1'b0,          "rst_busy",      busy, 0);
      check(done == 1'b0,          "rst_done",      done, 0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      for (int v = 0; v < 7; v++)
         run_one(vecs[v].lc, vecs[v].md, vecs[v].extra, vecs[v].first_lat, vecs[v].span);

      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < 2**AW; a++) mem[a] = DW'($urandom);
         run_one($urandom_range(1, 20), $urandom_range(0, 2), 0, 3, -1);
      end

      // reset while two words sit in the buffer
      build_expect(8);
      clear_stats();
      @(posedge clk); #2;
      mode = 3;
      line_count = (AW+1)'(8);
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check(bus.out_valid == 1'b1 && issued - xfers == 2, "stalled_two_buffered", issued - xfers, 2);
      rst = 1'b1;
      #1;
      check(bus.rd_en == 1'b0 && bus.rd_addr == '0, "midrst_rd", {bus.rd_en, bus.rd_addr}, 0);
      check(bus.out_valid == 1'b0 && bus.out_last == 1'b0, "midrst_valid_last", {bus.out_valid, bus.out_last}, 0);
      check(bus.out_data == '0, "midrst_data", bus.out_data, 0);
      check(busy == 1'b0 && done == 1'b0, "midrst_busy_done", {busy, done}, 0);
      mon_en = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      mode = 0;
      mon_en = 1'b1;
      clear_stats();
      repeat (4) @(posedge clk);
      #2;
      check(done_cnt == 0 && valid_cnt == 0, "no_done_after_rst", {done_cnt, valid_cnt}, 0);
      for (int a = 0; a < 2**AW; a++) mem[a] = DW'(16'hA000 + a * 3);
      run_one(3, 0, 0, 3, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
